// File: rtl/stack_arb_pkg.sv
// Shared encodings and default sizes for the two-requester stack arbiter.
package stack_arb_pkg;

  localparam int          DEF_DATA_WIDTH  = 16;
  localparam logic [15:0] DEF_STACK_BASE  = 16'hFFFF;
  localparam int          DEF_STACK_DEPTH = 256;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_WR  = 3'd1,
    ST_POP_ADDR = 3'd2,
    ST_POP_DATA = 3'd3,
    ST_RESP     = 3'd4,
    ST_ERR      = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a one-hot grant; the grant is only issued while enabled.
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  // High when requester 1 holds the most recent grant; reset favours requester 0.
  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (|o_grant) begin
      r_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates push/pop requests from two clients onto one downward-growing memory stack.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] STACK_BASE  = DATA_WIDTH'(DEF_STACK_BASE),
  parameter int                    STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          req0_valid,
  input  logic                          req0_op,
  input  logic [DATA_WIDTH-1:0]         req0_wdata,
  output logic                          req0_ready,
  output logic                          req0_rvalid,
  output logic [DATA_WIDTH-1:0]         req0_rdata,
  output logic                          req0_err,
  input  logic                          req1_valid,
  input  logic                          req1_op,
  input  logic [DATA_WIDTH-1:0]         req1_wdata,
  output logic                          req1_ready,
  output logic                          req1_rvalid,
  output logic [DATA_WIDTH-1:0]         req1_rdata,
  output logic                          req1_err,
  output logic [DATA_WIDTH-1:0]         mem_sp,
  output logic [DATA_WIDTH-1:0]         mem_data,
  output logic                          mem_write,
  input  logic [DATA_WIDTH-1:0]         mem_sp_data,
  output logic [DATA_WIDTH-1:0]         sp_out,
  output logic                          stack_empty,
  output logic                          stack_full,
  output logic [$clog2(STACK_DEPTH):0]  count,
  output state_t                        dbg_state
);

  localparam int                    CW      = $clog2(STACK_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] SP_ONE  = 1;
  localparam logic [CW-1:0]         CNT_ONE = 1;

  // Handshake: a request is accepted in any cycle where reqN_valid and reqN_ready are both high.
  state_t                r_state, w_next;
  logic                  r_op, r_idx;
  logic [DATA_WIDTH-1:0] r_wdata, r_sp, r_rdata0, r_rdata1;
  logic [CW-1:0]         r_count;
  logic [1:0]            w_grant;
  logic                  w_en, w_accept, w_sel, w_op, w_empty, w_full;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_en     = (r_state == ST_IDLE) && !RST;
  assign w_accept = |w_grant;
  assign w_sel    = w_grant[1];
  assign w_op     = w_sel ? req1_op : req0_op;
  assign w_wdata  = w_sel ? req1_wdata : req0_wdata;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(STACK_DEPTH));

  rr_arbiter2 u_arb (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_req   ({req1_valid, req0_valid}),
    .i_en    (w_en),
    .o_grant (w_grant)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if ((w_op == OP_PUSH && w_full) || (w_op == OP_POP && w_empty)) w_next = ST_ERR;
          else if (w_op == OP_PUSH)                                        w_next = ST_PUSH_WR;
          else                                                             w_next = ST_POP_ADDR;
        end
      end
      ST_PUSH_WR:  w_next = ST_IDLE;
      ST_POP_ADDR: w_next = ST_POP_DATA;
      ST_POP_DATA: w_next = ST_RESP;
      ST_RESP:     w_next = ST_IDLE;
      ST_ERR:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_sp     <= STACK_BASE;
      r_count  <= '0;
      r_op     <= OP_PUSH;
      r_idx    <= 1'b0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= w_op;
        r_idx   <= w_sel;
        r_wdata <= w_wdata;
      end
      case (r_state)
        ST_PUSH_WR: begin
          r_sp    <= r_sp - SP_ONE;
          r_count <= r_count + CNT_ONE;
        end
        ST_POP_ADDR: begin
          r_sp    <= r_sp + SP_ONE;
          r_count <= r_count - CNT_ONE;
        end
        ST_POP_DATA: begin
          if (r_idx) r_rdata1 <= mem_sp_data;
          else       r_rdata0 <= mem_sp_data;
        end
        default: ;
      endcase
    end
  end

  // The pop address is the slot just above SP; once SP has moved, the default SP covers POP_DATA.
  assign mem_sp    = (r_state == ST_POP_ADDR) ? (r_sp + SP_ONE) : r_sp;
  assign mem_data  = (r_state == ST_PUSH_WR) ? r_wdata : '0;
  assign mem_write = (r_state == ST_PUSH_WR) && (r_op == OP_PUSH) && !RST;

  assign req0_ready  = w_grant[0];
  assign req1_ready  = w_grant[1];
  assign req0_rvalid = (r_state == ST_RESP) && !r_idx && !RST;
  assign req1_rvalid = (r_state == ST_RESP) &&  r_idx && !RST;
  assign req0_err    = (r_state == ST_ERR)  && !r_idx && !RST;
  assign req1_err    = (r_state == ST_ERR)  &&  r_idx && !RST;
  assign req0_rdata  = r_rdata0;
  assign req1_rdata  = r_rdata1;

  assign sp_out      = r_sp;
  assign stack_empty = w_empty;
  assign stack_full  = w_full;
  assign count       = r_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized and directed checks of stack_arbiter against a queue-based stack model.
`timescale 1ns/100ps
module tb_stack_arbiter;
  import stack_arb_pkg::*;

  localparam int          DW    = 16;
  localparam int          DEPTH = 4;
  localparam int          CW    = 3;
  localparam logic [15:0] BASE  = 16'hFFFF;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req0_valid = 1'b0, req0_op = 1'b0;
  logic          req1_valid = 1'b0, req1_op = 1'b0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          req0_ready, req0_rvalid, req0_err;
  logic          req1_ready, req1_rvalid, req1_err;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic [DW-1:0] mem_sp, mem_data, mem_sp_data, sp_out;
  logic          mem_write, stack_empty, stack_full;
  logic [CW-1:0] count;
  state_t        dbg_state;

  stack_arbiter #(.DATA_WIDTH(DW), .STACK_BASE(BASE), .STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .mem_sp(mem_sp), .mem_data(mem_data), .mem_write(mem_write), .mem_sp_data(mem_sp_data),
    .sp_out(sp_out), .stack_empty(stack_empty), .stack_full(stack_full), .count(count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / memory ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  logic [DW-1:0] mem [0:65535];
  always @(posedge CLK) begin
    if (mem_write) mem[mem_sp] <= mem_data;
    mem_sp_data <= mem[mem_sp];
  end

  // ---------------- scoreboard ----------------
  typedef enum int {EV_WR, EV_RV, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          idx;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe(input ev_kind_t kind, input int idx, input logic [15:0] addr,
                         input logic [15:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: kind %0d idx %0d addr %0h data %0h at cycle %0d",
               kind, idx, addr, data, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_idx", idx, e.idx);
      chk("event_cycle", cyc, e.cyc);
      chk("event_addr", addr, e.addr);
      chk("event_data", data, e.data);
    end
  endtask

  // Monitor: samples outputs 2ns after each rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (!RST) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL missing_event: kind %0d idx %0d due cycle %0d now %0d",
                   exp_q[0].kind, exp_q[0].idx, exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
        if (mem_write)   observe(EV_WR, 0, mem_sp, mem_data);
        if (req0_rvalid) observe(EV_RV, 0, 16'h0, req0_rdata);
        if (req1_rvalid) observe(EV_RV, 1, 16'h0, req1_rdata);
        if (req0_err)    observe(EV_ERR, 0, 16'h0, 16'h0);
        if (req1_err)    observe(EV_ERR, 1, 16'h0, 16'h0);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] stk[$];
  logic        m_last = 1'b1;
  int          m_busy = 0;

  function automatic logic [15:0] model_sp();
    return BASE - 16'(stk.size());
  endfunction

  // Called at a falling edge: drives one cycle of requests, predicts and checks the grant.
  task automatic do_cycle(input logic v0, input logic o0, input logic [15:0] d0,
                          input logic v1, input logic o1, input logic [15:0] d1);
    int          win;
    logic        op;
    logic [15:0] d;
    exp_t        e;
    req0_valid = v0; req0_op = o0; req0_wdata = d0;
    req1_valid = v1; req1_op = o1; req1_wdata = d1;
    #1;
    win = -1;
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      chk("sp_out_idle", sp_out, model_sp());
      chk("count_idle", count, stk.size());
      chk("empty_idle", stack_empty, stk.size() == 0);
      chk("full_idle", stack_full, stk.size() == DEPTH);
      if (v0 && v1)  win = m_last ? 0 : 1;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
    end
    chk("ready0", req0_ready, win == 0);
    chk("ready1", req1_ready, win == 1);
    if (win >= 0) begin
      m_last = (win == 1);
      op     = (win == 1) ? o1 : o0;
      d      = (win == 1) ? d1 : d0;
      e.idx  = win;
      e.addr = 16'h0;
      e.data = 16'h0;
      e.cyc  = cyc + 1;
      m_busy = 1;
      if (op == OP_PUSH && stk.size() == DEPTH) begin
        e.kind = EV_ERR;
      end else if (op == OP_POP && stk.size() == 0) begin
        e.kind = EV_ERR;
      end else if (op == OP_PUSH) begin
        e.kind = EV_WR;
        e.idx  = 0;
        e.addr = model_sp();
        e.data = d;
        stk.push_back(d);
      end else begin
        e.kind = EV_RV;
        e.data = stk.pop_back();
        e.cyc  = cyc + 3;
        m_busy = 3;
      end
      exp_q.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req0_valid = 1'b1; req0_op = OP_PUSH;
    req1_valid = 1'b0;
    #1;
    chk("ready0_in_reset", req0_ready, 1'b0);
    req0_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    stk.delete();
    m_last = 1'b1;
    m_busy = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] a, b, saved;

  initial begin
    @(negedge CLK);
    do_reset();
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_rvalid", {req0_rvalid, req1_rvalid}, 2'b00);
    chk("rst_err", {req0_err, req1_err}, 2'b00);
    chk("rst_rdata0", req0_rdata, 16'h0);
    chk("rst_rdata1", req1_rdata, 16'h0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_sp", sp_out, 16'hFFFF);
    chk("rst_count", count, 0);
    chk("rst_empty", stack_empty, 1'b1);
    chk("rst_full", stack_full, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);

    // Single push then pop from the other requester.
    do_cycle(1'b1, OP_PUSH, 16'h1234, 1'b0, 1'b0, 16'h0);
    chk("push_mem_write", mem_write, 1'b1);
    chk("push_mem_sp", mem_sp, 16'hFFFF);
    chk("push_mem_data", mem_data, 16'h1234);
    idle(1);
    chk("push_sp_after", sp_out, 16'hFFFE);
    chk("push_count_after", count, 1);
    do_cycle(1'b0, 1'b0, 16'h0, 1'b1, OP_POP, 16'h0);
    chk("pop_mem_sp", mem_sp, 16'hFFFF);
    chk("pop_no_write", mem_write, 1'b0);
    idle(3);
    chk("pop_rdata1_held", req1_rdata, 16'h1234);
    chk("pop_sp_after", sp_out, 16'hFFFF);
    chk("pop_empty_after", stack_empty, 1'b1);

    // Simultaneous pushes: requester 0 wins first after reset.
    do_reset();
    a = 16'($urandom);
    b = 16'($urandom);
    do_cycle(1'b1, OP_PUSH, a, 1'b1, OP_PUSH, b);
    do_cycle(1'b0, 1'b0, 16'h0, 1'b1, OP_PUSH, b);
    do_cycle(1'b0, 1'b0, 16'h0, 1'b1, OP_PUSH, b);
    idle(2);
    chk("both_mem_ffff", mem[16'hFFFF], a);
    chk("both_mem_fffe", mem[16'hFFFE], b);
    chk("both_sp", sp_out, 16'hFFFD);

    // Error cases: pop on empty, push on full.
    do_reset();
    do_cycle(1'b1, OP_POP, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("empty_pop_err", req0_err, 1'b1);
    chk("empty_pop_no_write", mem_write, 1'b0);
    chk("empty_pop_sp", sp_out, 16'hFFFF);
    idle(1);
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b1, OP_PUSH, 16'(16'hA000 + i), 1'b0, 1'b0, 16'h0);
      idle(1);
    end
    do_cycle(1'b1, OP_PUSH, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    chk("full_push_err", req0_err, 1'b1);
    chk("full_push_no_write", mem_write, 1'b0);
    idle(1);
    chk("full_count", count, DEPTH);
    chk("full_flag", stack_full, 1'b1);

    // Reset landing in the write cycle abandons the push.
    do_reset();
    saved = mem[16'hFFFF];
    req0_valid = 1'b1; req0_op = OP_PUSH; req0_wdata = ~saved;
    #1;
    chk("rstmid_ready0", req0_ready, 1'b1);
    @(posedge CLK);
    #1;
    chk("rstmid_write_before", mem_write, 1'b1);
    req0_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("rstmid_write_suppressed", mem_write, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rstmid_sp", sp_out, 16'hFFFF);
    chk("rstmid_count", count, 0);
    chk("rstmid_state", dbg_state, ST_IDLE);
    chk("rstmid_mem", mem[16'hFFFF], saved);
    stk.delete();
    m_last = 1'b1;
    m_busy = 0;
    @(negedge CLK);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    end
    idle(6);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
